// File: rtl/regfile_sb.sv
// Parametrised register file with async clear, optional zero R0,
// write-to-read bypass and a per-register busy scoreboard.
module regfile_sb #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int NUM_RD  = 2,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     any_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW    = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_nxt;
  logic              wr_ok;
  logic              rsv_ok;

  // R0 writes/reserves are dropped when it is hardwired to zero
  assign wr_ok  = rst_n && write_en &&
                  !(ZERO_R0 != 0 && wr_addr == '0);
  assign rsv_ok = rst_n && rsv_en &&
                  !(ZERO_R0 != 0 && rsv_addr == '0);

  // reserve is applied last so it wins a same-address collision
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)
      busy_nxt[wr_addr] = 1'b0;
    if (rsv_ok)
      busy_nxt[rsv_addr] = 1'b1;
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_ok)
        regs[wr_addr] <= wr_data;
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero;
    logic              hit;

    assign a    = rd_addr[g*ADDR_W +: ADDR_W];
    assign zero = (ZERO_R0 != 0) && (a == '0);
    assign hit  = (BYPASS != 0) && wr_ok && (wr_addr == a);

    assign rd_data[g*DATA_W +: DATA_W] =
      zero ? '0 : (hit ? wr_data : regs[a]);
    assign rd_busy[g] = busy[a] && !hit;
  end

  assign busy_cnt = cnt_q;
  assign any_busy = (cnt_q != '0);

endmodule
